// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
//  arb_state_t : grant state of the arbiter (idle, CPU owns memory, EXT owns memory)
//  grant_t     : identifies the port that held the memory most recently
//  rr_pick     : round-robin winner when both ports request from idle
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_EXT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_EXT = 1'b1
  } grant_t;

  // The port that was not served last wins a tie.
  function automatic arb_state_t rr_pick(input grant_t last_grant);
    return (last_grant == GNT_EXT) ? ARB_CPU : ARB_EXT;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port dmem between the MIPS load/store
// port and an external requester (loader/DMA/debug) that may lock the memory
// for bursts. The grant is a registered state; mem_* and the acks are decoded
// from that state, so a request made while idle is acknowledged one cycle later.
// A pending CPU request is guaranteed service after MAX_WAIT cycles of EXT grant.
//
// Ports
//  clk                    clock, all state on the rising edge
//  reset                  asynchronous active-low reset
//  cpu_req/we/addr/wdata  CPU request, held stable until cpu_ack
//  cpu_rdata, cpu_ack     CPU read data (valid in ack cycle), transfer done
//  cpu_stall              CPU access pending and not completing this cycle
//  ext_req/we/addr/wdata  external request, held stable until ext_ack
//  ext_lock               keep the EXT grant after the current beat
//  ext_rdata, ext_ack     external read data, transfer done
//  mem_we/addr/wdata      dmem controls
//  mem_rdata              dmem combinational read data
module dmem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_ack,
  input  logic          ext_lock,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  import mem_arb_pkg::*;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = {WAIT_W{1'b1}};

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  grant_t            last_grant_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              starve_s;

  // Starvation guard: the CPU has already waited MAX_WAIT-1 EXT cycles and this is the last one.
  assign starve_s = (state_r == ARB_EXT) && cpu_req && (wait_cnt_r == WAIT_LAST);

  // Next-state selection for the grant FSM.
  always_comb begin
    next_state_s = ARB_IDLE;
    case (state_r)
      ARB_IDLE: begin
        if (cpu_req && ext_req) begin
          next_state_s = rr_pick(last_grant_r);
        end else if (cpu_req) begin
          next_state_s = ARB_CPU;
        end else if (ext_req) begin
          next_state_s = ARB_EXT;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      // The CPU transfer completes in this cycle; never hold the grant a second cycle.
      ARB_CPU: begin
        if (ext_req) begin
          next_state_s = ARB_EXT;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      // The lock keeps EXT even with no request, unless the CPU is about to starve.
      ARB_EXT: begin
        if (starve_s) begin
          next_state_s = ARB_CPU;
        end else if (ext_lock) begin
          next_state_s = ARB_EXT;
        end else if (cpu_req) begin
          next_state_s = ARB_CPU;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      default: begin
        next_state_s = ARB_IDLE;
      end
    endcase
  end

  // Grant state, round-robin history and CPU wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= GNT_EXT;
      wait_cnt_r   <= {WAIT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (state_r == ARB_CPU) begin
        last_grant_r <= GNT_CPU;
      end else if (state_r == ARB_EXT) begin
        last_grant_r <= GNT_EXT;
      end else begin
        last_grant_r <= last_grant_r;
      end
      if ((state_r == ARB_EXT) && cpu_req) begin
        if (wait_cnt_r != WAIT_SAT) begin
          wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
          wait_cnt_r <= wait_cnt_r;
        end
      end else begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end
    end
  end

  // Memory mux and acknowledges decoded from the grant state; idle drives zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    cpu_ack   = 1'b0;
    ext_ack   = 1'b0;
    case (state_r)
      ARB_CPU: begin
        mem_we    = cpu_we & cpu_req;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ack   = cpu_req;
      end
      ARB_EXT: begin
        mem_we    = ext_we & ext_req;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        ext_ack   = ext_req;
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        cpu_ack   = 1'b0;
        ext_ack   = 1'b0;
      end
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural dmem and a
// reference memory model for the randomized traffic phase.
module tb_dmem_arbiter;

  localparam int DW       = 32;
  localparam int AW       = 32;
  localparam int MAX_WAIT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ext_req, ext_we, ext_ack, ext_lock;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] dmem    [0:255] = '{default: 32'h0};
  logic [31:0] ref_mem [0:255] = '{default: 32'h0};

  always #5 clk = ~clk;

  dmem_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack), .ext_lock(ext_lock),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port data memory: combinational read, synchronous write.
  assign mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(); smp();
    checks++;
    if ({cpu_ack, ext_ack, mem_we} !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_idle: acks/we=%b addr=%h wdata=%h, expected all zero",
                         {cpu_ack, ext_ack, mem_we}, mem_addr, mem_wdata);
    end
    cyc();
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD_BEEF;
    smp();
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_first_latency: cpu_ack=%b expected 0", cpu_ack); end
    cyc(); smp();
    checks++;
    if (cpu_ack !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL reset_pre_abort: cpu_ack=%b mem_we=%b expected 1 1", cpu_ack, mem_we);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({cpu_ack, ext_ack, mem_we} !== 3'b000 || mem_addr !== 32'h0 || cpu_stall !== 1'b1) begin
      errors++; $display("FAIL reset_abort: acks/we=%b addr=%h stall=%b expected 000 0 1",
                         {cpu_ack, ext_ack, mem_we}, mem_addr, cpu_stall);
    end
    cyc();
    checks++;
    if (dmem[8] !== 32'h0) begin errors++; $display("FAIL reset_no_write: dmem=%h expected 0", dmem[8]); end
    reset = 1'b1;
    smp();
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_release_idle: cpu_ack=%b expected 0", cpu_ack); end
    cyc(); smp();
    checks++;
    if (cpu_ack !== 1'b1 || mem_addr !== 32'h20 || mem_we !== 1'b1) begin
      errors++; $display("FAIL reset_release_ack: ack=%b addr=%h we=%b expected 1 20 1", cpu_ack, mem_addr, mem_we);
    end
    cyc();
    cpu_req = 1'b0;
    checks++;
    if (dmem[8] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_retry_write: dmem=%h expected deadbeef", dmem[8]); end
  endtask

  task automatic test_cpu_store_load();
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h54; cpu_wdata = 32'h7;
    smp();
    checks++;
    if (cpu_ack !== 1'b0 || cpu_stall !== 1'b1) begin
      errors++; $display("FAIL sw_latency: ack=%b stall=%b expected 0 1", cpu_ack, cpu_stall);
    end
    cyc(); smp();
    checks++;
    if (cpu_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h54 || mem_wdata !== 32'h7 ||
        cpu_stall !== 1'b0 || ext_ack !== 1'b0) begin
      errors++; $display("FAIL sw_ack: ack=%b we=%b addr=%h wdata=%h stall=%b expected 1 1 54 7 0",
                         cpu_ack, mem_we, mem_addr, mem_wdata, cpu_stall);
    end
    cyc();
    cpu_we = 1'b0; cpu_wdata = 32'h0;
    smp();
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL lw_latency: ack=%b expected 0", cpu_ack); end
    cyc(); smp();
    checks++;
    if (cpu_ack !== 1'b1 || mem_we !== 1'b0 || cpu_rdata !== 32'h7) begin
      errors++; $display("FAIL lw_data: ack=%b we=%b rdata=%h expected 1 0 7", cpu_ack, mem_we, cpu_rdata);
    end
    cyc();
    cpu_req = 1'b0;
  endtask

  task automatic test_contention();
    int  nc, ne;
    logic exp_cpu;
    nc = 0; ne = 0;
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'hC000;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h64; ext_wdata = 32'hE000;
    for (int k = 0; k <= 6; k++) begin
      smp();
      exp_cpu = (k % 2 == 1);
      checks++;
      if (k == 0) begin
        if (cpu_ack !== 1'b0 || ext_ack !== 1'b0) begin
          errors++; $display("FAIL contend_idle: acks=%b%b expected 00", cpu_ack, ext_ack);
        end
      end else if (cpu_ack !== exp_cpu || ext_ack !== !exp_cpu ||
                   mem_addr !== (exp_cpu ? cpu_addr : ext_addr)) begin
        errors++; $display("FAIL contend_order k=%0d: cpu_ack=%b ext_ack=%b addr=%h expected cpu_ack=%b",
                           k, cpu_ack, ext_ack, mem_addr, exp_cpu);
      end
      cyc();
      if (k > 0 && exp_cpu) begin
        nc++;
        cpu_req = (nc < 3); cpu_addr = 32'h60 + 32'(8 * nc); cpu_wdata = 32'hC000 + 32'(nc);
      end else if (k > 0) begin
        ne++;
        ext_req = (ne < 3); ext_addr = 32'h64 + 32'(8 * ne); ext_wdata = 32'hE000 + 32'(ne);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dmem[24 + 2 * i] !== 32'hC000 + 32'(i) || dmem[25 + 2 * i] !== 32'hE000 + 32'(i)) begin
        errors++; $display("FAIL contend_data i=%0d: cpu=%h ext=%h", i, dmem[24 + 2 * i], dmem[25 + 2 * i]);
      end
    end
  endtask

  task automatic test_lock_starvation();
    int   b;
    int   cpu_slot;
    logic exp_cpu, exp_ext;
    b = 0;
    cpu_slot = 4 + MAX_WAIT;
    ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b1; ext_addr = 32'h200; ext_wdata = 32'h100;
    cpu_we = 1'b0; cpu_addr = 32'h54; cpu_wdata = 32'h0;
    for (int t = 0; t <= 21; t++) begin
      smp();
      exp_cpu = (t == cpu_slot);
      exp_ext = (t > 0) && !exp_cpu && (b < 20);
      checks++;
      if (cpu_ack !== exp_cpu || ext_ack !== exp_ext) begin
        errors++; $display("FAIL burst_grant t=%0d: cpu_ack=%b ext_ack=%b expected %b %b",
                           t, cpu_ack, ext_ack, exp_cpu, exp_ext);
      end
      if (exp_cpu) begin
        checks++;
        if (cpu_rdata !== 32'h7 || mem_we !== 1'b0) begin
          errors++; $display("FAIL burst_cpu_read: rdata=%h we=%b expected 7 0", cpu_rdata, mem_we);
        end
      end
      cyc();
      if (exp_ext) b++;
      cpu_req   = (t + 1 >= 4) && (t + 1 <= cpu_slot);
      ext_req   = (b < 20);
      ext_lock  = (b < 20);
      ext_addr  = 32'h200 + 32'(4 * b);
      ext_wdata = 32'h100 + 32'(b);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (dmem[128 + i] !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL burst_data beat=%0d: got %h expected %h", i, dmem[128 + i], 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_lock_idle();
    cyc();
    ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b1; ext_addr = 32'h300; ext_wdata = 32'h5A5A_0001;
    smp();
    checks++;
    if (ext_ack !== 1'b0) begin errors++; $display("FAIL lock_latency: ext_ack=%b expected 0", ext_ack); end
    cyc(); smp();
    checks++;
    if (ext_ack !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL lock_beat: ext_ack=%b we=%b expected 1 1", ext_ack, mem_we);
    end
    cyc();
    ext_req = 1'b0; ext_addr = 32'h304; ext_wdata = 32'h0000_0BAD;
    for (int i = 0; i < 3; i++) begin
      smp();
      checks++;
      if (ext_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h304 || cpu_ack !== 1'b0) begin
        errors++; $display("FAIL lock_hold i=%0d: ext_ack=%b we=%b addr=%h expected 0 0 304",
                           i, ext_ack, mem_we, mem_addr);
      end
      cyc();
    end
    ext_lock = 1'b0;
    smp(); cyc(); smp();
    checks++;
    if (mem_addr !== 32'h0 || dmem[193] !== 32'h0 || dmem[192] !== 32'h5A5A_0001) begin
      errors++; $display("FAIL lock_release: addr=%h d304=%h d300=%h expected 0 0 5a5a0001",
                         mem_addr, dmem[193], dmem[192]);
    end
    cyc();
    ext_we = 1'b0;
  endtask

  task automatic test_random();
    int   cw, ew;
    logic ca, ea;
    cw = 0; ew = 0;
    for (int c = 0; c < 10040; c++) begin
      if (c >= 10000 && !cpu_req && !ext_req) break;
      smp();
      ca = cpu_ack; ea = ext_ack;
      checks++;
      if (cpu_stall !== (cpu_req & ~cpu_ack)) begin
        errors++; $display("FAIL rnd_stall c=%0d: stall=%b expected %b", c, cpu_stall, cpu_req & ~cpu_ack);
      end
      checks++;
      if (ca === 1'b1 && ea === 1'b1) begin errors++; $display("FAIL rnd_both_ack c=%0d: both acks high", c); end
      checks++;
      if (mem_we !== ((ca && cpu_we) || (ea && ext_we))) begin
        errors++; $display("FAIL rnd_mem_we c=%0d: mem_we=%b without matching write ack", c, mem_we);
      end
      if (ca) begin
        if (cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
        else begin
          checks++;
          if (cpu_rdata !== ref_mem[cpu_addr[9:2]]) begin
            errors++; $display("FAIL rnd_cpu_read c=%0d addr=%h: got %h expected %h",
                               c, cpu_addr, cpu_rdata, ref_mem[cpu_addr[9:2]]);
          end
        end
      end
      if (ea) begin
        if (ext_we) ref_mem[ext_addr[9:2]] = ext_wdata;
        else begin
          checks++;
          if (ext_rdata !== ref_mem[ext_addr[9:2]]) begin
            errors++; $display("FAIL rnd_ext_read c=%0d addr=%h: got %h expected %h",
                               c, ext_addr, ext_rdata, ref_mem[ext_addr[9:2]]);
          end
        end
      end
      cw = (cpu_req && !ca) ? cw + 1 : 0;
      ew = (ext_req && !ea) ? ew + 1 : 0;
      checks++;
      if (cw > MAX_WAIT + 1 || ew > 2) begin
        errors++; $display("FAIL rnd_wait_bound c=%0d: cpu_wait=%0d ext_wait=%0d limits %0d 2", c, cw, ew, MAX_WAIT + 1);
      end
      cyc();
      if (ca || !cpu_req) begin
        cpu_req   = (c < 10000) && ($urandom_range(0, 9) < 6);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 32'h380 + ($urandom_range(0, 15) << 2);
        cpu_wdata = $urandom;
      end
      if (ea || !ext_req) begin
        ext_req   = (c < 10000) && ($urandom_range(0, 9) < 5);
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = 32'h380 + ($urandom_range(0, 15) << 2);
        ext_wdata = $urandom;
      end
      ext_lock = (c < 10000) && ($urandom_range(0, 3) == 0);
    end
    checks++;
    if (cpu_req || ext_req) begin
      errors++; $display("FAIL rnd_drain: cpu_req=%b ext_req=%b still pending", cpu_req, ext_req);
    end
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0; ext_lock = 1'b0;
    test_reset();
    test_cpu_store_load();
    test_contention();
    test_lock_starvation();
    test_lock_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
